// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback request ports (A, B) plus the
// registered register-file write port and the priority debug flag.
//   master modport : writeback sources / register file side (drives requests)
//   slave  modport : the arbiter (drives readies and the write port)
interface regfile_wb_arbiter_if #(
  parameter int unsigned REG_ADDR = 5,
  parameter int unsigned REG_SIZE = 32
);
  logic                a_valid;
  logic                a_ready;
  logic [REG_ADDR-1:0] a_wreg;
  logic [REG_SIZE-1:0] a_wdata;
  logic                b_valid;
  logic                b_ready;
  logic [REG_ADDR-1:0] b_wreg;
  logic [REG_SIZE-1:0] b_wdata;
  logic                regwrite;
  logic [REG_ADDR-1:0] wreg;
  logic [REG_SIZE-1:0] wdata;
  logic                b_prio;

  modport slave (
    input  a_valid, a_wreg, a_wdata, b_valid, b_wreg, b_wdata,
    output a_ready, b_ready, regwrite, wreg, wdata, b_prio
  );

  modport master (
    output a_valid, a_wreg, a_wdata, b_valid, b_wreg, b_wdata,
    input  a_ready, b_ready, regwrite, wreg, wdata, b_prio
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback (port A) and a long-latency unit (port B). A wins by default; the
// write is registered, so the register file sees it one cycle after the grant.
// Writes to r0 complete the handshake but never assert regwrite.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   wb   - regfile_wb_arbiter_if.slave: a_/b_ valid/ready/wreg/wdata requests,
//          registered regwrite/wreg/wdata outputs, b_prio debug flag
//
// Build option: WB_ARB_FAIR_EN
//   defined   - starvation counter promotes B to priority (PRI_B) after
//               STARVE_MAX consecutive refused cycles
//   undefined - strict A priority, no FSM/counter, b_prio tied low
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned REG_ADDR   = 5,
  parameter int unsigned REG_SIZE   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb
);

  logic                grant_a;
  logic                grant_b;
  logic                transfer;
  logic [REG_ADDR-1:0] sel_wreg;
  logic [REG_SIZE-1:0] sel_wdata;
  logic                regwrite_q;
  logic [REG_ADDR-1:0] wreg_q;
  logic [REG_SIZE-1:0] wdata_q;

`ifdef WB_ARB_FAIR_EN
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PRI_A;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;

    case (state)
      PRI_A: begin
        grant_a = wb.a_valid;
        grant_b = wb.b_valid && !wb.a_valid;
        if (wb.b_valid && !grant_b && (starve_cnt == CNT_LAST))
          state_nxt = PRI_B;
      end
      PRI_B: begin
        grant_b   = wb.b_valid;
        grant_a   = wb.a_valid && !wb.b_valid;
        // In PRI_B a pending B is always granted, so either B transferred or
        // b_valid was low: both conditions return to PRI_A after one cycle.
        state_nxt = PRI_A;
      end
      default: state_nxt = PRI_A;
    endcase

    if (!wb.b_valid || grant_b)
      starve_nxt = '0;
    else if (starve_cnt != CNT_MAX)
      starve_nxt = starve_cnt + 1'b1;
  end

  assign wb.b_prio = (state == PRI_B);
`else
  assign grant_a   = wb.a_valid;
  assign grant_b   = wb.b_valid && !wb.a_valid;
  assign wb.b_prio = 1'b0;

  // Fairness parameters have no effect in the strict-priority build.
  logic unused_cfg;
  assign unused_cfg = ^{STARVE_MAX, CNT_W};
`endif

  assign wb.a_ready = grant_a;
  assign wb.b_ready = grant_b;

  assign transfer  = grant_a || grant_b;
  assign sel_wreg  = grant_b ? wb.b_wreg  : wb.a_wreg;
  assign sel_wdata = grant_b ? wb.b_wdata : wb.a_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= transfer && (sel_wreg != '0);
      if (transfer) begin
        wreg_q  <= sel_wreg;
        wdata_q <= sel_wdata;
      end
    end
  end

  assign wb.regwrite = regwrite_q;
  assign wb.wreg     = wreg_q;
  assign wb.wdata    = wdata_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the single register-file write port between two writeback sources. Port A is the in-order pipeline writeback (ALU/load). Port B is a long-latency unit (mul/div). The block sits between the writeback stage and the register file's `regwrite`/`wreg`/`wdata` inputs, and presents a registered, single-cycle write to the register file. Port A has priority by default. A starvation counter guarantees that port B makes forward progress.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive cycles B may be refused before B gets priority; legal range 1..15.
- `CNT_W`, default 4: width of the starvation counter; must hold `STARVE_MAX`.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` in 1: port A has a write pending.
- `a_ready` out 1: port A write accepted this cycle.
- `a_wreg` in `REG_ADDR`: port A destination register.
- `a_wdata` in `REG_SIZE`: port A write data.
- `b_valid` in 1: port B has a write pending.
- `b_ready` out 1: port B write accepted this cycle.
- `b_wreg` in `REG_ADDR`: port B destination register.
- `b_wdata` in `REG_SIZE`: port B write data.
- `regwrite` out 1: register-file write enable, registered.
- `wreg` out `REG_ADDR`: register-file write address, registered.
- `wdata` out `REG_SIZE`: register-file write data, registered.
- `b_prio` out 1: arbiter is in `PRI_B`, for debug and performance counters.

## Operation
- Handshake: a transfer occurs when `x_valid && x_ready`. The requester holds `x_valid`, `x_wreg` and `x_wdata` stable until the transfer. `x_ready` is combinational from the valids and the state, and never depends on `x_ready` itself.
- At most one of `a_ready`/`b_ready` is high in any cycle. If a valid is asserted, one ready is high; the write port is never idle while a request waits.
- FSM states are `PRI_A` (reset state) and `PRI_B`.
  - In `PRI_A`: grant A if `a_valid`, otherwise grant B if `b_valid`.
  - In `PRI_B`: grant B if `b_valid`, otherwise grant A.
  - `PRI_A` -> `PRI_B` on the edge where `starve_cnt == STARVE_MAX-1` and B is refused in that cycle.
  - `PRI_B` -> `PRI_A` on the first edge after a B transfer, or when `b_valid` is low.
- `starve_cnt`:
  - Increments on each cycle with `b_valid && !b_ready`.
  - Clears on a B transfer or when `b_valid` is low.
  - Saturates at `STARVE_MAX`.
- Output register, on each edge:
  - `regwrite <= transfer && (granted wreg != 0)`.
  - `wreg`/`wdata` load the granted port's values on any transfer; otherwise they hold.
- Writes to r0 are accepted (ready high, handshake completes) but produce `regwrite=0`.
- Same destination from both ports in one cycle: only the granted port writes; the loser writes in a later cycle, so the later writer wins in the register file.
- Reset mid-operation: a write sitting in the output register is discarded and not retried.
- Reset values: `regwrite=0`, `wreg=0`, `wdata=0`, `b_prio=0`, state `PRI_A`, `starve_cnt=0`.

## Timing
- Request at cycle N with ready high -> `regwrite`/`wreg`/`wdata` valid during cycle N+1 -> register-file write on the edge ending N+1. Latency is 1 cycle.
- Throughput is one write per cycle, sustained, from either port or mixed.
- With `WB_ARB_FAIR_EN` defined, under continuous A and B requests B waits at most `STARVE_MAX` cycles. Its grant occurs in cycle `STARVE_MAX+1` after B first asserts valid.

## Configuration
- `WB_ARB_FAIR_EN`:
  - Defined: `PRI_B`, `starve_cnt` and `b_prio` behave as above.
  - Undefined: strict A priority. The FSM and counter are not built, `b_prio` is tied 0, and B is granted only in cycles with `a_valid=0`. Under continuous A traffic B may starve; this is acceptable only for configurations with no port B unit.

## Test plan
- Reset, then A writes r5=0x1234 at cycle 2 with B idle -> `a_ready=1` at cycle 2; `regwrite=1`, `wreg=5`, `wdata=0x1234` at cycle 3, low at cycle 4.
- A and B both valid at cycle 2 (A: r3=0xA, B: r4=0xB), `STARVE_MAX=4`, FAIR on -> A granted at cycle 2; A holds valid with new data each cycle; B granted at cycle 6 with `b_prio=1`; `regwrite` with r4=0xB at cycle 7; `b_prio=0` at cycle 7.
- Same scenario as above with `WB_ARB_FAIR_EN` undefined -> B never granted while A stays valid; B granted in the first cycle `a_valid=0`.
- A writes r0=0xFFFF -> `a_ready=1`, `regwrite=0` the next cycle; a following A write to r1 still completes normally.
- A and B both target r7 (A=0x1, B=0x2), FAIR on, `starve_cnt` at `STARVE_MAX-1` -> A granted this cycle, B next; r7 read back as 0x2.
- `rst` asserted asynchronously mid-cycle while `regwrite=1` -> `regwrite`, `wreg`, `wdata`, `b_prio` go 0 immediately without a clock edge; the next grant after release follows `PRI_A` rules.
